carregador_padroes: RTL and testbench

Loads the eight 16-bit display patterns consumed by the pattern selector. It accepts a stream of 16-bit words over a valid/ready handshake and assembles them into an 8-entry staging bank. When the eighth word arrives, it commits the whole bank to the P1..P8 outputs in a single cycle. Downstream scanning logic therefore never sees a partially written frame. It sits between the pattern source (host or ROM sequencer) and the scan multiplexer.

---
 rtl/carregador_padroes.sv | 92 +++++++++
 tb/tb_carregador_padroes.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/carregador_padroes.sv
// rtl/carregador_padroes.sv - stages eight 16-bit pattern words and commits them to P1..P8 atomically
module carregador_padroes (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] Dado,
  input  logic        Valido,
  input  logic        Abortar,
  output logic        Pronto,
  output logic [2:0]  Contador,
  output logic        Quadro,
  output logic [15:0] P1,
  output logic [15:0] P2,
  output logic [15:0] P3,
  output logic [15:0] P4,
  output logic [15:0] P5,
  output logic [15:0] P6,
  output logic [15:0] P7,
  output logic [15:0] P8
);

  typedef enum logic [1:0] {
    INICIO = 2'd0,
    CARGA  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state;
  logic        pronto;
  logic        quadro;
  logic [2:0]  contador;
  logic [15:0] staging  [8];
  logic [15:0] padroes  [8];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= INICIO;
      pronto   <= 1'b0;
      quadro   <= 1'b0;
      contador <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        staging[i] <= 16'h0000;
        padroes[i] <= 16'h0000;
      end
    end else begin
      quadro <= 1'b0;
      case (state)
        INICIO: begin
          state  <= CARGA;
          pronto <= 1'b1;
        end
        CARGA: begin
          // Abort takes priority over a simultaneous valid word
          if (Abortar) begin
            contador <= 3'd0;
          end else if (Valido) begin
            staging[contador] <= Dado;
            contador          <= contador + 3'd1;
            if (contador == 3'd7) begin
              state  <= COMMIT;
              pronto <= 1'b0;
            end
          end
        end
        COMMIT: begin
          for (int i = 0; i < 8; i++) begin
            padroes[i] <= staging[i];
          end
          quadro <= 1'b1;
          state  <= CARGA;
          pronto <= 1'b1;
        end
        default: begin
          state  <= INICIO;
          pronto <= 1'b0;
        end
      endcase
    end
  end

  assign Pronto   = pronto;
  assign Quadro   = quadro;
  assign Contador = contador;
  assign P1 = padroes[0];
  assign P2 = padroes[1];
  assign P3 = padroes[2];
  assign P4 = padroes[3];
  assign P5 = padroes[4];
  assign P6 = padroes[5];
  assign P7 = padroes[6];
  assign P8 = padroes[7];

endmodule

// File: tb/tb_carregador_padroes.sv
// tb/tb_carregador_padroes.sv - table-driven and directed checks for carregador_padroes
module tb_carregador_padroes;

  logic        Clock;
  logic        Reset;
  logic [15:0] Dado;
  logic        Valido;
  logic        Abortar;
  logic        Pronto;
  logic [2:0]  Contador;
  logic        Quadro;
  logic [15:0] P1, P2, P3, P4, P5, P6, P7, P8;

  int nvec;
  int nerr;
  int pulses;

  carregador_padroes dut (
    .Clock(Clock), .Reset(Reset), .Dado(Dado), .Valido(Valido), .Abortar(Abortar),
    .Pronto(Pronto), .Contador(Contador), .Quadro(Quadro),
    .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7), .P8(P8)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct packed {
    logic         rst;
    logic         vld;
    logic         abt;
    logic [15:0]  dado;
    logic         pronto;
    logic [2:0]   cnt;
    logic         quadro;
    logic [127:0] p;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic v, input logic a, input logic [15:0] d,
                              input logic pr, input logic [2:0] c, input logic q,
                              input logic [127:0] p);
    vec_t x;
    x.rst = r; x.vld = v; x.abt = a; x.dado = d;
    x.pronto = pr; x.cnt = c; x.quadro = q; x.p = p;
    return x;
  endfunction

  function automatic logic [127:0] p_now();
    return {P8, P7, P6, P5, P4, P3, P2, P1};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read at the same point
  task automatic drive(input logic r, input logic v, input logic a, input logic [15:0] d);
    Reset = r; Valido = v; Abortar = a; Dado = d;
    @(posedge Clock);
    #1;
    if (Quadro === 1'b1) pulses++;
  endtask

  task automatic check_all(input string name, input logic pr, input logic [2:0] c,
                           input logic q, input logic [127:0] p);
    check({name, ".pronto"}, {127'd0, Pronto}, {127'd0, pr});
    check({name, ".cnt"}, {125'd0, Contador}, {125'd0, c});
    check({name, ".quadro"}, {127'd0, Quadro}, {127'd0, q});
    check({name, ".p"}, p_now(), p);
  endtask

  initial begin
    vec_t         tbl[$];
    logic [127:0] pf, p1111, pa, pb, pe;

    nvec = 0; nerr = 0; pulses = 0;
    Reset = 1'b1; Valido = 1'b0; Abortar = 1'b0; Dado = 16'h0000;

    for (int i = 0; i < 8; i++) begin
      pf[16*i +: 16]    = 16'h0001 << i;
      p1111[16*i +: 16] = 16'h1111 * 16'(i + 1);
      pa[16*i +: 16]    = 16'hA000 + 16'(i);
      pb[16*i +: 16]    = 16'hB000 + 16'(i);
      pe[16*i +: 16]    = 16'hE000 + 16'(i);
    end

    // Reset held two cycles, then one INICIO cycle before Pronto rises
    tbl.push_back(mk(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 3'd0, 1'b0, 128'h0));
    tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 3'd0, 1'b0, 128'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h4321, 1'b1, 3'd0, 1'b0, 128'h0));

    // Back-to-back frame with Valido held; the word offered during COMMIT is not consumed
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0001 << i, (i < 7), 3'((i + 1) % 8), 1'b0, 128'h0));
    tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'h5555, 1'b1, 3'd0, 1'b1, pf));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h5555, 1'b1, 3'd0, 1'b0, pf));

    // Gapped stream: idle cycles carry junk data that must be ignored
    for (int i = 0; i < 8; i++) begin
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'h0001 << i, (i < 7), 3'((i + 1) % 8), 1'b0, pf));
      tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'hFFFF, 1'b1, 3'((i + 1) % 8), (i == 7), pf));
    end
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd0, 1'b0, pf));

    // Abort after three words; abort cycle carries a valid word that must be dropped
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'hDEAD, 1'b1, 3'(i + 1), 1'b0, pf));
    tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b1, 3'd0, 1'b0, pf));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b0, 1'b1, 1'b0, 16'h1111 * 16'(i + 1), (i < 7), 3'((i + 1) % 8), 1'b0, pf));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd0, 1'b1, p1111));
    tbl.push_back(mk(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 3'd0, 1'b0, p1111));

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].rst, tbl[k].vld, tbl[k].abt, tbl[k].dado);
      check_all($sformatf("vec%0d", k), tbl[k].pronto, tbl[k].cnt, tbl[k].quadro, tbl[k].p);
    end

    // Two frames: A must stay visible for the whole load of B
    pulses = 0;
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 16'hA000 + 16'(i));
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    check_all("frameA", 1'b1, 3'd0, 1'b1, pa);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 16'hB000 + 16'(i));
      check($sformatf("holdA%0d", i), p_now(), pa);
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    check_all("frameB", 1'b1, 3'd0, 1'b1, pb);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    check("two_pulses", 128'(pulses), 128'd2);

    // Abort during COMMIT is ignored
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 16'hE000 + 16'(i));
    drive(1'b0, 1'b1, 1'b1, 16'h9999);
    check_all("abort_in_commit", 1'b1, 3'd0, 1'b1, pe);

    // Reset after five words of a frame
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 1'b0, 16'hC000 + 16'(i));
    check("five_words.cnt", {125'd0, Contador}, 128'd5);
    drive(1'b1, 1'b1, 1'b0, 16'hC005);
    check_all("reset_mid", 1'b0, 3'd0, 1'b0, 128'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    check_all("reset_mid_rel", 1'b1, 3'd0, 1'b0, 128'h0);
    pulses = 0;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 16'hC100);
    check_all("restart", 1'b1, 3'd3, 1'b0, 128'h0);
    drive(1'b0, 1'b0, 1'b1, 16'h0);

    // Reset during the COMMIT cycle: no commit, no pulse
    for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 1'b0, 16'hF000 + 16'(i));
    check_all("pre_commit", 1'b0, 3'd0, 1'b0, 128'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0);
    check_all("reset_commit", 1'b0, 3'd0, 1'b0, 128'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0);
    check_all("after_reset_commit", 1'b1, 3'd0, 1'b0, 128'h0);
    check("no_pulse", 128'(pulses), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
